// File: rtl/debug_pkg.sv
// Shared types and constants for the SPI command queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: capture-FSM state enum and overflow-policy constants.
package debug_pkg;

    // Capture FSM: one push per assertion of the SPI valid level.
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } cap_state_t;

    // Overflow policy values for the DROP_OLDEST parameter.
    localparam int POLICY_DROP_NEWEST = 0;
    localparam int POLICY_DROP_OLDEST = 1;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with selectable overflow policy.
// Latency: a write is visible at head_data the cycle after push when it was empty.
// Backpressure: never stalls push; on full it drops the incoming entry or overwrites the oldest.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push, push_data  : write request and data
//   pop              : read request (ignored when empty)
//   head_data        : oldest entry, 0 when empty
//   occupancy, empty : fill level and empty flag
//   accepted, dropped: per-cycle strobes for a written entry / a lost entry
module sync_fifo
    import debug_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DROP_OLDEST = POLICY_DROP_NEWEST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty,
    output logic                     accepted,
    output logic                     dropped
);

    localparam int  PTR_W     = $clog2(DEPTH);
    localparam bit  OVERWRITE = (DROP_OLDEST == POLICY_DROP_OLDEST);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [PTR_W:0]        occ;
    logic                  full;

    logic do_pop;
    logic room;
    logic overwrite;
    logic write_en;
    logic head_adv;

    assign full  = (occ == (PTR_W+1)'(DEPTH));
    assign empty = (occ == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // with a simultaneous pop is never a drop.
    always_comb begin
        do_pop    = pop & ~empty;
        room      = ~full | do_pop;
        overwrite = push & ~room & OVERWRITE;
        write_en  = (push & room) | overwrite;
        dropped   = push & ~room;
        accepted  = write_en;
        // Overwrite only happens with no pop, so the two never double-advance.
        head_adv  = do_pop | overwrite;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
        end else begin
            if (write_en) tail_ptr <= tail_ptr + 1'b1;
            if (head_adv) head_ptr <= head_ptr + 1'b1;
            // Overwrite keeps occupancy at DEPTH; push+pop leaves it unchanged.
            case ({write_en & ~overwrite, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: head_data is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (write_en) mem[tail_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[head_ptr];
    assign occupancy = occ;

endmodule

// File: rtl/spi_command_queue.sv
// Buffers SPI command bytes and issues them one at a time, free-running or tick-paced.
// Latency: a captured byte is offered on cmd_valid the cycle after capture (free mode).
// Backpressure: holds entries while cmd_ready is low; overflow drops per DROP_OLDEST and is counted.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   spi_data, spi_data_valid          : byte and valid level from the SPI receiver
//   spi_clear                         : one-cycle pulse asking the receiver to drop valid
//   game_tick, issue_on_tick          : level game clock and tick-paced issue select
//   cmd_valid, cmd_ready, cmd_data    : command handshake towards the executioner
//   occupancy                         : entries held
//   accepted_count, dropped_count     : saturating telemetry counters
//   overflow                          : sticky flag, set on the first drop
module spi_command_queue
    import debug_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int DROP_OLDEST = POLICY_DROP_NEWEST
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    spi_data,
    input  logic                     spi_data_valid,
    output logic                     spi_clear,
    input  logic                     game_tick,
    input  logic                     issue_on_tick,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [DATA_WIDTH-1:0]    cmd_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [COUNT_WIDTH-1:0]   accepted_count,
    output logic [COUNT_WIDTH-1:0]   dropped_count,
    output logic                     overflow
);

    cap_state_t state;
    cap_state_t state_next;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_accepted;
    logic       fifo_dropped;
    logic       tick_prev;
    logic       tick_edge;
    logic       tick_pending;

    // ---------------- capture FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (spi_data_valid)  state_next = WAIT_LOW;
            WAIT_LOW: if (!spi_data_valid) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Push only on the IDLE->WAIT_LOW transition, so a lingering valid
    // level yields a single command.
    always_comb begin
        push = (state == IDLE) & spi_data_valid;
    end

    // Clear pulse follows the capture edge by one cycle.
    always_ff @(posedge clk) begin
        if (reset) spi_clear <= 1'b0;
        else       spi_clear <= push;
    end

    // ---------------- storage ----------------
    sync_fifo #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .DROP_OLDEST (DROP_OLDEST)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (spi_data),
        .pop       (pop),
        .head_data (cmd_data),
        .occupancy (occupancy),
        .empty     (fifo_empty),
        .accepted  (fifo_accepted),
        .dropped   (fifo_dropped)
    );

    // ---------------- issue / tick logic ----------------
    assign cmd_valid = ~fifo_empty & (~issue_on_tick | tick_pending);
    assign pop       = cmd_valid & cmd_ready;
    assign tick_edge = game_tick & ~tick_prev;

    // tick_prev resets high so a tick already high at reset release is not an edge.
    // A tick only arms when there is something to issue; an edge coinciding
    // with a pop re-arms rather than clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_prev    <= 1'b1;
            tick_pending <= 1'b0;
        end else begin
            tick_prev <= game_tick;
            if (tick_edge && !fifo_empty) tick_pending <= 1'b1;
            else if (pop)                 tick_pending <= 1'b0;
        end
    end

    // ---------------- telemetry ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted_count <= '0;
            dropped_count  <= '0;
            overflow       <= 1'b0;
        end else begin
            if (fifo_accepted && (accepted_count != '1))
                accepted_count <= accepted_count + 1'b1;
            if (fifo_dropped && (dropped_count != '1))
                dropped_count <= dropped_count + 1'b1;
            if (fifo_dropped)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_command_queue.sv
module tb_spi_command_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] spi_data;
    logic       spi_data_valid;
    logic       game_tick;
    logic       issue_on_tick;
    logic       cmd_ready;

    // Instance 0: drop-newest policy; instance 1: drop-oldest policy.
    logic       clr0, clr1, vld0, vld1, ovf0, ovf1;
    logic [7:0] dat0, dat1, acc0, acc1, drp0, drp1;
    logic [2:0] occ0, occ1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_command_queue #(.DEPTH(4), .DATA_WIDTH(8), .COUNT_WIDTH(8), .DROP_OLDEST(0)) dut0 (
        .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
        .spi_clear(clr0), .game_tick(game_tick), .issue_on_tick(issue_on_tick),
        .cmd_ready(cmd_ready), .cmd_valid(vld0), .cmd_data(dat0), .occupancy(occ0),
        .accepted_count(acc0), .dropped_count(drp0), .overflow(ovf0)
    );

    spi_command_queue #(.DEPTH(4), .DATA_WIDTH(8), .COUNT_WIDTH(8), .DROP_OLDEST(1)) dut1 (
        .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
        .spi_clear(clr1), .game_tick(game_tick), .issue_on_tick(issue_on_tick),
        .cmd_ready(cmd_ready), .cmd_valid(vld1), .cmd_data(dat1), .occupancy(occ1),
        .accepted_count(acc1), .dropped_count(drp1), .overflow(ovf1)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] d);
        spi_data       = d;
        spi_data_valid = 1'b1;
        step();
        spi_data_valid = 1'b0;
        step();
    endtask

    task automatic tick_issue(input logic [7:0] exp_d, input logic [2:0] exp_occ);
        game_tick = 1'b1;
        step();
        check("tick_valid", 32'(vld0), 32'd1);
        check("tick_data", 32'(dat0), 32'(exp_d));
        step();
        check("tick_pop_valid", 32'(vld0), 32'd0);
        check("tick_pop_occ", 32'(occ0), 32'(exp_occ));
        game_tick = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] exp0 [4];
        logic [7:0] exp1 [4];
        int clr_count;

        vecs[0] = '{8'h05, 8'd1};
        vecs[1] = '{8'hA3, 8'd2};
        vecs[2] = '{8'hFF, 8'd3};
        vecs[3] = '{8'h00, 8'd4};

        reset          = 1'b1;
        spi_data       = 8'h00;
        spi_data_valid = 1'b0;
        game_tick      = 1'b0;
        issue_on_tick  = 1'b0;
        cmd_ready      = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_clear", 32'(clr0), 32'd0);
        check("rst_valid", 32'(vld0), 32'd0);
        check("rst_data", 32'(dat0), 32'd0);
        check("rst_occ", 32'(occ0), 32'd0);
        check("rst_acc", 32'(acc0), 32'd0);
        check("rst_drop", 32'(drp0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);

        // Free mode, consumer ready: each command issues the cycle after capture.
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            spi_data       = vecs[i].data;
            spi_data_valid = 1'b1;
            step();
            check("free_clear_hi", 32'(clr0), 32'd1);
            check("free_valid", 32'(vld0), 32'd1);
            check("free_data", 32'(dat0), 32'(vecs[i].data));
            check("free_acc", 32'(acc0), 32'(vecs[i].exp_acc));
            spi_data_valid = 1'b0;
            step();
            check("free_clear_lo", 32'(clr0), 32'd0);
            check("free_valid_lo", 32'(vld0), 32'd0);
            check("free_occ", 32'(occ0), 32'd0);
        end

        // Valid held for 10 cycles: single push, single clear.
        cmd_ready      = 1'b0;
        spi_data       = 8'h42;
        spi_data_valid = 1'b1;
        clr_count      = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (clr0) clr_count++;
        end
        spi_data_valid = 1'b0;
        step();
        check("hold_clear_pulses", 32'(clr_count), 32'd1);
        check("hold_occ", 32'(occ0), 32'd1);
        check("hold_acc", 32'(acc0), 32'd5);
        check("hold_data", 32'(dat0), 32'h42);
        cmd_ready = 1'b1;
        step();
        check("hold_drain", 32'(occ0), 32'd0);

        // Tick mode: three queued commands, one issue per tick.
        issue_on_tick = 1'b1;
        push_cmd(8'h21);
        push_cmd(8'h22);
        push_cmd(8'h23);
        check("tick_wait_valid", 32'(vld0), 32'd0);
        check("tick_wait_occ", 32'(occ0), 32'd3);
        tick_issue(8'h21, 3'd2);
        tick_issue(8'h22, 3'd1);
        tick_issue(8'h23, 3'd0);
        // Tick on an empty queue is discarded.
        game_tick = 1'b1;
        step();
        check("empty_tick_valid", 32'(vld0), 32'd0);
        game_tick = 1'b0;
        step();
        push_cmd(8'h24);
        step();
        check("late_push_valid", 32'(vld0), 32'd0);
        check("late_push_occ", 32'(occ0), 32'd1);
        tick_issue(8'h24, 3'd0);

        // Overflow, consumer stalled: 6 pushes into 4 entries.
        issue_on_tick = 1'b0;
        cmd_ready     = 1'b0;
        for (int i = 0; i < 6; i++) push_cmd(8'h31 + 8'(i));
        check("ovf0_occ", 32'(occ0), 32'd4);
        check("ovf0_drop", 32'(drp0), 32'd2);
        check("ovf0_flag", 32'(ovf0), 32'd1);
        check("ovf0_acc", 32'(acc0), 32'd13);
        check("ovf1_occ", 32'(occ1), 32'd4);
        check("ovf1_drop", 32'(drp1), 32'd2);
        check("ovf1_flag", 32'(ovf1), 32'd1);
        check("ovf1_acc", 32'(acc1), 32'd15);
        exp0 = '{8'h31, 8'h32, 8'h33, 8'h34};
        exp1 = '{8'h33, 8'h34, 8'h35, 8'h36};
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain0_data", 32'(dat0), 32'(exp0[i]));
            check("drain1_data", 32'(dat1), 32'(exp1[i]));
            step();
        end
        cmd_ready = 1'b0;
        check("drain0_empty", 32'(occ0), 32'd0);
        check("drain1_empty", 32'(occ1), 32'd0);

        // Full queue with push and pop in the same cycle: no drop.
        for (int i = 0; i < 4; i++) push_cmd(8'h41 + 8'(i));
        check("full_acc0", 32'(acc0), 32'd17);
        spi_data       = 8'h45;
        spi_data_valid = 1'b1;
        cmd_ready      = 1'b1;
        step();
        cmd_ready      = 1'b0;
        check("pp_occ0", 32'(occ0), 32'd4);
        check("pp_drop0", 32'(drp0), 32'd2);
        check("pp_head0", 32'(dat0), 32'h42);
        check("pp_drop1", 32'(drp1), 32'd2);
        check("pp_acc1", 32'(acc1), 32'd20);
        spi_data_valid = 1'b0;
        step();

        // Reset mid-stream, with game_tick high across the release.
        reset         = 1'b1;
        game_tick     = 1'b1;
        issue_on_tick = 1'b1;
        step();
        check("mid_rst_valid", 32'(vld0), 32'd0);
        check("mid_rst_occ", 32'(occ0), 32'd0);
        check("mid_rst_acc", 32'(acc0), 32'd0);
        check("mid_rst_drop", 32'(drp0), 32'd0);
        check("mid_rst_ovf", 32'(ovf0), 32'd0);
        check("mid_rst_data", 32'(dat0), 32'd0);
        check("mid_rst_occ1", 32'(occ1), 32'd0);
        reset          = 1'b0;
        spi_data       = 8'h77;
        spi_data_valid = 1'b1;
        step();
        check("post_rst_clear", 32'(clr0), 32'd1);
        check("post_rst_occ", 32'(occ0), 32'd1);
        check("post_rst_no_tick", 32'(vld0), 32'd0);
        spi_data_valid = 1'b0;
        step();
        step();
        check("post_rst_no_tick2", 32'(vld0), 32'd0);
        // Leaving tick mode takes effect immediately.
        issue_on_tick = 1'b0;
        #1;
        check("mode_switch_valid", 32'(vld0), 32'd1);
        check("mode_switch_data", 32'(dat0), 32'h77);
        cmd_ready = 1'b1;
        step();
        check("mode_switch_pop", 32'(occ0), 32'd0);

        // Accepted counter saturates instead of wrapping.
        for (int i = 0; i < 256; i++) push_cmd(8'(i));
        check("sat_acc0", 32'(acc0), 32'd255);
        check("sat_acc1", 32'(acc1), 32'd255);
        check("sat_occ0", 32'(occ0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
